// File: rtl/aes_pkg.sv
// Shared AES-128 constants, FSM state type and GF(2^8) helper.
package aes_pkg;

  localparam logic [3:0] AES_NR     = 4'd10;
  localparam logic [7:0] RCON_INIT  = 8'h01;
  localparam logic [7:0] XTIME_POLY = 8'h1b;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] r);
    return {r[6:0], 1'b0} ^ (r[7] ? XTIME_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box applied to all four bytes of a 32-bit word in parallel.
module aes_sbox (
  input  logic [31:0] word,
  output logic [31:0] sub_word
);

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Four independent byte lookups.
  always_comb begin
    sub_word = {SBOX[word[31:24]], SBOX[word[23:16]],
                SBOX[word[15:8]],  SBOX[word[7:0]]};
  end

endmodule

// File: rtl/aes_key_expand.sv
// AES-128 key schedule: emits round keys 0..10 over a valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for start; outputs not valid
// RUN   | round_key/round_idx valid, advancing on each accepted transfer
module aes_key_expand
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key,
  input  logic         rk_ready,
  output logic         rk_valid,
  output logic [127:0] round_key,
  output logic [3:0]   round_idx,
  output logic         busy,
  output logic         done
);

  state_t       state, state_nxt;
  logic [7:0]   rcon;
  logic         load, adv, fin;
  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  sub_rot, t, n0, n1, n2, n3;

  assign {w0, w1, w2, w3} = round_key;

  aes_sbox u_sbox (
    .word     ({w3[23:0], w3[31:24]}),
    .sub_word (sub_rot)
  );

  // Next round key from the current one: single combinational step.
  always_comb begin
    t  = sub_rot ^ {rcon, 24'h0};
    n0 = w0 ^ t;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode and datapath strobes.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    adv       = 1'b0;
    fin       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (rk_ready) begin
          if (round_idx == AES_NR) begin
            fin       = 1'b1;
            state_nxt = IDLE;
          end else begin
            adv = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Round key, round counter, rcon and done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      round_key <= '0;
      round_idx <= '0;
      rcon      <= RCON_INIT;
      done      <= 1'b0;
    end else begin
      done <= fin;
      if (load) begin
        round_key <= key;
        round_idx <= '0;
        rcon      <= RCON_INIT;
      end else if (adv) begin
        round_key <= {n0, n1, n2, n3};
        round_idx <= round_idx + 4'd1;
        rcon      <= xtime(rcon);
      end
    end
  end

  assign busy     = (state == RUN);
  assign rk_valid = (state == RUN);

endmodule

// File: tb/tb_aes_key_expand.sv
// Self-checking bench for aes_key_expand against a FIPS-197 style reference.
module tb_aes_key_expand;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [127:0] key = '0;
  logic         rk_ready = 1'b0;
  logic         rk_valid;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         busy;
  logic         done;

  int errors = 0;
  int checks = 0;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  logic [127:0] exp_keys [11];
  logic [127:0] obs_key [12];
  logic [3:0]   obs_idx [12];
  int           n_obs, done_cnt, done_cyc, stall_bad;

  always #5 clk = ~clk;

  aes_key_expand dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .key       (key),
    .rk_ready  (rk_ready),
    .rk_valid  (rk_valid),
    .round_key (round_key),
    .round_idx (round_idx),
    .busy      (busy),
    .done      (done)
  );

  // ---------------- reference model (field arithmetic, FIPS word recurrence)
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] ref_sbox(input logic [7:0] a);
    logic [7:0] inv = 8'h01;
    logic [7:0] s;
    for (int i = 0; i < 254; i++) inv = gf_mul(inv, a);
    s = inv;
    for (int r = 1; r <= 4; r++) s = s ^ ((inv << r) | (inv >> (8 - r)));
    return s ^ 8'h63;
  endfunction

  task automatic model_expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {ref_sbox(tmp[31:24]), ref_sbox(tmp[23:16]),
               ref_sbox(tmp[15:8]), ref_sbox(tmp[7:0])} ^ {rc, 24'h0};
        rc = gf_mul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++) exp_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // ---------------- stimulus helpers (no comparisons inside)
  task automatic do_start(input logic [127:0] k);
    @(negedge clk);
    start = 1'b1;
    key   = k;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Records transfers from the current negedge on; pct = rk_ready probability.
  task automatic collect(input int pct, input bit noise, output bit tmo);
    logic [127:0] prev_key;
    logic [3:0]   prev_idx;
    bit           have_prev, rdy;
    n_obs = 0; done_cnt = 0; done_cyc = 0; stall_bad = 0;
    have_prev = 0; tmo = 1; prev_key = '0; prev_idx = '0;
    for (int c = 1; c <= 400; c++) begin
      if (done) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = c;
      end
      if (have_prev && rk_valid && (round_key !== prev_key || round_idx !== prev_idx))
        stall_bad++;
      if (n_obs >= 11 && done_cyc != 0 && c > done_cyc) begin
        tmo = 0;
        break;
      end
      if (noise && n_obs < 11) begin
        start = 1'($urandom_range(0, 1));
        key   = {$urandom, $urandom, $urandom, $urandom};
      end else begin
        start = 1'b0;
      end
      rdy = ($urandom_range(0, 99) < pct);
      rk_ready = rdy;
      if (rk_valid && rdy) begin
        if (n_obs < 12) begin
          obs_key[n_obs] = round_key;
          obs_idx[n_obs] = round_idx;
        end
        n_obs++;
        have_prev = 0;
      end else begin
        have_prev = rk_valid;
        prev_key  = round_key;
        prev_idx  = round_idx;
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  // ---------------- tests
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (rk_valid !== 1'b0) begin errors++; $display("FAIL reset_rk_valid got %0b want 0", rk_valid); end
    checks++; if (round_key !== '0) begin errors++; $display("FAIL reset_round_key got %h want 0", round_key); end
    checks++; if (round_idx !== 4'd0) begin errors++; $display("FAIL reset_round_idx got %0d want 0", round_idx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", done); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fips();
    bit tmo;
    model_expand(FIPS_KEY);
    do_start(FIPS_KEY);
    collect(100, 0, tmo);
    checks++; if (tmo !== 1'b0 || n_obs != 11) begin errors++; $display("FAIL fips_count got %0d tmo=%0b want 11", n_obs, tmo); end
    for (int i = 0; i < 11 && i < n_obs; i++) begin
      checks++; if (obs_key[i] !== exp_keys[i] || obs_idx[i] !== 4'(i)) begin
        errors++; $display("FAIL fips_round%0d got %h idx %0d want %h idx %0d", i, obs_key[i], obs_idx[i], exp_keys[i], i);
      end
    end
    checks++; if (obs_key[1] !== 128'ha0fafe1788542cb123a339392a6c7605) begin errors++; $display("FAIL fips_r1_const got %h want a0fafe1788542cb123a339392a6c7605", obs_key[1]); end
    checks++; if (obs_key[10] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin errors++; $display("FAIL fips_r10_const got %h want d014f9a8c9ee2589e13f0cc8b6630ca6", obs_key[10]); end
    checks++; if (done_cyc != 12) begin errors++; $display("FAIL fips_done_cycle got %0d want 12", done_cyc); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL fips_done_count got %0d want 1", done_cnt); end
    checks++; if (busy !== 1'b0 || rk_valid !== 1'b0) begin errors++; $display("FAIL fips_idle_after got busy=%0b valid=%0b want 0 0", busy, rk_valid); end
  endtask

  task automatic test_zero();
    bit tmo;
    model_expand('0);
    do_start('0);
    collect(100, 0, tmo);
    checks++; if (tmo !== 1'b0 || n_obs != 11) begin errors++; $display("FAIL zero_count got %0d tmo=%0b want 11", n_obs, tmo); end
    for (int i = 0; i < 11 && i < n_obs; i++) begin
      checks++; if (obs_key[i] !== exp_keys[i]) begin errors++; $display("FAIL zero_round%0d got %h want %h", i, obs_key[i], exp_keys[i]); end
    end
    checks++; if (obs_key[1] !== 128'h62636363626363636263636362636363) begin errors++; $display("FAIL zero_r1_const got %h want 62636363626363636263636362636363", obs_key[1]); end
    checks++; if (obs_key[10] !== 128'hb4ef5bcb3e92e21123e951cf6f8f188e) begin errors++; $display("FAIL zero_r10_const got %h want b4ef5bcb3e92e21123e951cf6f8f188e", obs_key[10]); end
  endtask

  task automatic test_stalls();
    bit tmo;
    model_expand(FIPS_KEY);
    do_start(FIPS_KEY);
    collect(40, 0, tmo);
    checks++; if (tmo !== 1'b0 || n_obs != 11) begin errors++; $display("FAIL stall_count got %0d tmo=%0b want 11", n_obs, tmo); end
    for (int i = 0; i < 11 && i < n_obs; i++) begin
      checks++; if (obs_key[i] !== exp_keys[i] || obs_idx[i] !== 4'(i)) begin
        errors++; $display("FAIL stall_round%0d got %h idx %0d want %h idx %0d", i, obs_key[i], obs_idx[i], exp_keys[i], i);
      end
    end
    checks++; if (stall_bad != 0) begin errors++; $display("FAIL stall_stable got %0d changes want 0", stall_bad); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL stall_done_count got %0d want 1", done_cnt); end
  endtask

  task automatic test_ignore_start();
    bit tmo;
    logic [127:0] k;
    k = {$urandom, $urandom, $urandom, $urandom};
    model_expand(k);
    do_start(k);
    collect(60, 1, tmo);
    checks++; if (tmo !== 1'b0 || n_obs != 11) begin errors++; $display("FAIL ignore_count got %0d tmo=%0b want 11", n_obs, tmo); end
    for (int i = 0; i < 11 && i < n_obs; i++) begin
      checks++; if (obs_key[i] !== exp_keys[i] || obs_idx[i] !== 4'(i)) begin
        errors++; $display("FAIL ignore_round%0d got %h idx %0d want %h idx %0d", i, obs_key[i], obs_idx[i], exp_keys[i], i);
      end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL ignore_done_count got %0d want 1", done_cnt); end
  endtask

  task automatic test_rst_mid();
    bit tmo;
    bit seen_done;
    int waited;
    logic [127:0] k;
    do_start(FIPS_KEY);
    rk_ready = 1'b1;
    waited = 0;
    while (round_idx !== 4'd5 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checks++; if (round_idx !== 4'd5) begin errors++; $display("FAIL rst_reach_idx5 got %0d want 5", round_idx); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if ({rk_valid, busy, done} !== 3'b000 || round_key !== '0 || round_idx !== 4'd0) begin
      errors++; $display("FAIL rst_mid_outputs got valid=%0b busy=%0b done=%0b key=%h idx=%0d want all 0", rk_valid, busy, done, round_key, round_idx);
    end
    seen_done = 0;
    repeat (8) begin
      @(negedge clk);
      if (done || busy) seen_done = 1;
    end
    checks++; if (seen_done) begin errors++; $display("FAIL rst_mid_no_done got activity=1 want 0"); end
    k = {$urandom, $urandom, $urandom, $urandom};
    model_expand(k);
    do_start(k);
    collect(70, 0, tmo);
    checks++; if (tmo !== 1'b0 || n_obs != 11) begin errors++; $display("FAIL rst_restart_count got %0d tmo=%0b want 11", n_obs, tmo); end
    for (int i = 0; i < 11 && i < n_obs; i++) begin
      checks++; if (obs_key[i] !== exp_keys[i]) begin errors++; $display("FAIL rst_restart_round%0d got %h want %h", i, obs_key[i], exp_keys[i]); end
    end
  endtask

  task automatic test_start_in_done();
    bit tmo;
    int waited;
    do_start(FIPS_KEY);
    rk_ready = 1'b1;
    waited = 0;
    while (done !== 1'b1 && waited < 30) begin
      @(negedge clk);
      waited++;
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL sid_done_seen got %0b want 1", done); end
    start = 1'b1;
    key   = '0;
    @(negedge clk);
    start = 1'b0;
    checks++; if (rk_valid !== 1'b1 || busy !== 1'b1 || round_idx !== 4'd0 || round_key !== '0) begin
      errors++; $display("FAIL sid_accept got valid=%0b busy=%0b idx=%0d key=%h want 1 1 0 0", rk_valid, busy, round_idx, round_key);
    end
    model_expand('0);
    collect(100, 0, tmo);
    checks++; if (tmo !== 1'b0 || n_obs != 11 || obs_key[10] !== exp_keys[10]) begin
      errors++; $display("FAIL sid_sequence got n=%0d r10=%h want 11 %h", n_obs, obs_key[10], exp_keys[10]);
    end
  endtask

  task automatic test_back_to_back();
    bit tmo;
    logic [127:0] k;
    for (int n = 0; n < 3; n++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      model_expand(k);
      do_start(k);
      collect(80, 0, tmo);
      checks++; if (tmo !== 1'b0 || n_obs != 11) begin errors++; $display("FAIL b2b%0d_count got %0d want 11", n, n_obs); end
      for (int i = 0; i < 11 && i < n_obs; i++) begin
        checks++; if (obs_key[i] !== exp_keys[i]) begin errors++; $display("FAIL b2b%0d_round%0d got %h want %h", n, i, obs_key[i], exp_keys[i]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fips();
    test_zero();
    test_stalls();
    test_ignore_start();
    test_rst_mid();
    test_start_in_done();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aes_key_expand.md
# aes_key_expand

AES-128 encryption-side key schedule engine. Loads a 128-bit cipher key and produces the 11 round keys (round 0..10) one per accepted transfer, using the forward S-box in SubWord. It sits beside the inverse-S-box decryption datapath and feeds both the encryption round pipeline and the round-key store that decryption reads in reverse order.

## Interface
Parameters: none (AES-128 fixed: Nk=4, Nr=10).
- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- start  input  1  request expansion; sampled only when busy=0
- key  input  128  cipher key, sampled on the accepted start edge; bits [127:96] = w0
- rk_ready  input  1  downstream accepts round_key this cycle
- rk_valid  output  1  round_key/round_idx valid
- round_key  output  128  current round key, [127:96] = first word
- round_idx  output  4  round number 0..10 of round_key
- busy  output  1  expansion in progress (state RUN)
- done  output  1  one-cycle pulse after round 10 is accepted

## Operation
- States: IDLE, RUN.
- IDLE: busy=0, rk_valid=0. start=1 -> load round_key=key, round_idx=0, rcon=8'h01, rk_valid=1, go RUN.
- RUN: busy=1, rk_valid=1. Transfer = rk_valid & rk_ready.
  - Transfer with round_idx<10: round_key <= next key, round_idx++, rcon <= xtime(rcon).
  - Transfer with round_idx==10: rk_valid<=0, done<=1 for one cycle, go IDLE.
  - No transfer: round_key, round_idx, rcon held stable.
- Next key from current words w0..w3: t = SubWord(RotWord(w3)) ^ {rcon,24'h0}; n0=w0^t, n1=w1^n0, n2=w2^n1, n3=w3^n2.
- RotWord {a,b,c,d} -> {b,c,d,a}. SubWord = forward AES S-box per byte.
- xtime(r) = {r[6:0],1'b0} ^ (r[7] ? 8'h1b : 8'h00); sequence 01,02,04,08,10,20,40,80,1b,36.
- start while busy=1 ignored; key changes after load have no effect.
- start in the done cycle is accepted (state is IDLE).

## Timing
- Reset values: rk_valid=0, round_key=0, round_idx=0, busy=0, done=0, rcon=01, state IDLE.
- rst=1 mid-expansion: next edge returns to reset values; no done pulse; partial sequence abandoned.
- Start accepted at edge k -> round 0 visible from cycle k+1.
- rk_ready held high: rounds 0..10 in cycles k+1..k+11, done=1 in cycle k+12, next start acceptable in k+12.
- Backpressure: round_key/round_idx stable while rk_valid=1 and rk_ready=0, any duration.
- Next-key logic single-cycle combinational (4 S-box lookups + XOR chain); no pipeline bubbles.

## Structure
- Shared package aes_pkg: AES_NR=10, RCON_INIT=8'h01, XTIME_POLY=8'h1b, state enum {IDLE,RUN}, xtime function.
- Sub-module aes_sbox: forward S-box, 32-bit word in/out, four parallel byte lookups (encryption-direction counterpart of the inverse-S-box word unit). One instance, input RotWord(w3).
- Top holds FSM, round_key register, round_idx counter, rcon register.

## Test plan
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1 -> round 1 a0fafe1788542cb123a339392a6c7605, round 10 d014f9a8c9ee2589e13f0cc8b6630ca6, done in cycle k+12.
- All-zero key -> round 1 62636363626363636263636362636363, round 10 b4ef5bcb3e92e21123e951cf6f8f188e.
- Random rk_ready stalls on FIPS key -> same 11 keys in order, outputs stable during every stall, exactly one done.
- start pulses and key changes during RUN -> ignored, sequence matches original key.
- rst asserted at round_idx=5 -> next cycle all outputs 0, no done; new start then yields full correct sequence.
- start asserted in done cycle with zero key -> accepted, round 0 = 0 in the following cycle.
